// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX/MEM boundary register with valid/ready backpressure.
// A 2-entry skid buffer (main + skid) keeps in_ready purely registered, so a
// stalling memory stage never creates a combinational ready path into EX.
// Optional: define EX_MEM_STALL_CNT_EN to add the 32-bit stallCnt output.
module ex_mem_skid_stage #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wbEnIn,
    input  logic              memREnIn,
    input  logic              memWEnIn,
    input  logic [DATA_W-1:0] aluResIn,
    input  logic [DATA_W-1:0] valRmIn,
    input  logic [DEST_W-1:0] destIn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wbEnOut,
    output logic              memREnOut,
    output logic              memWEnOut,
    output logic [DATA_W-1:0] aluResOut,
    output logic [DATA_W-1:0] valRmOut,
    output logic [DEST_W-1:0] destOut
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stallCnt
`endif
);

    typedef struct packed {
        logic              wb;
        logic              mr;
        logic              mw;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rm;
        logic [DEST_W-1:0] dest;
    } beat_t;

    // EMPTY: main invalid; ONE: main valid only; FULL: main and skid valid.
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;
    beat_t  main_q, skid_q, in_beat;
    logic   push, pop;
    logic   load_main_in, load_main_skid, load_skid;

    assign in_beat   = '{wb: wbEnIn, mr: memREnIn, mw: memWEnIn,
                         alu: aluResIn, rm: valRmIn, dest: destIn};

    // Both handshake signals come straight from the state flops.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Control bits are qualified so a bubble never carries a stale write.
    assign wbEnOut   = main_q.wb & out_valid;
    assign memREnOut = main_q.mr & out_valid;
    assign memWEnOut = main_q.mw & out_valid;
    assign aluResOut = main_q.alu;
    assign valRmOut  = main_q.rm;
    assign destOut   = main_q.dest;

    // Next-state and entry-load decode; flush squashes everything to EMPTY.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: if (push) begin
                state_nxt    = ONE;
                load_main_in = 1'b1;
            end
            ONE: begin
                if (push && pop) begin
                    load_main_in = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (pop) begin
                state_nxt      = ONE;
                load_main_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    // Entry storage; data is left untouched on flush since valid bits gate it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_beat;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_beat;
        end
    end

`ifdef EX_MEM_STALL_CNT_EN
    // Counts cycles where a beat waits on downstream; survives flush, wraps.
    always_ff @(posedge clk) begin
        if (!rst)                        stallCnt <= '0;
        else if (out_valid && !out_ready) stallCnt <= stallCnt + 32'd1;
    end
`endif

endmodule
